// File: rtl/read_return_buffer_if.sv
// Handshake bundle between axi_read, the DRAM read backend and the read
// return buffer. The buffer connects through the slave modport; the master
// modport is the surrounding environment (front end plus backend).
interface read_return_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              rstrobe;
    logic [ADDR_W-1:0] selected_addr;
    logic [1:0]        tid_in;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_rerr;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [1:0]        tid_out;
    logic              rerr;
    logic              rfull;
    logic              stray_err;

    modport master (
        output rstrobe, selected_addr, tid_in, mem_ack, mem_rdata, mem_rvalid,
               mem_rerr, ren,
        input  mem_req, mem_addr, rdata, rvalid, tid_out, rerr, rfull, stray_err
    );

    modport slave (
        input  rstrobe, selected_addr, tid_in, mem_ack, mem_rdata, mem_rvalid,
               mem_rerr, ren,
        output mem_req, mem_addr, rdata, rvalid, tid_out, rerr, rfull, stray_err
    );
endinterface

// File: rtl/read_return_buffer.sv
// Read return buffer: queues beat requests from axi_read, issues them in
// order to the memory backend, tags returning beats with their transaction
// ID and presents them through a show-ahead FIFO under credit backpressure.

// Show-ahead FIFO with cleared storage on reset. Callers guarantee no push
// when full and no pop when empty.
module rrb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;

    // Next storage, pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push) begin
            mem_d[wp_q] = din;
            wp_d        = wp_q + AW'(1);
        end
        if (pop) rp_d = rp_q + AW'(1);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = mem_q[rp_q];
    assign cnt  = cnt_q;
endmodule

module read_return_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input logic                clk,
    input logic                n_rst,
    read_return_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   credits_used_q, credits_used_d;
    logic            stray_err_q, stray_err_d;

    logic            accept, pop, req_pop, tag_pop;
    logic            req_empty, tag_empty, data_empty;
    logic [CW-1:0]   req_cnt, tag_cnt, data_cnt, req_cnt_nx;
    logic [ADDR_W+1:0] req_head;
    logic [1:0]      tag_head;
    logic [DATA_W+2:0] data_head;

    // Credits are taken at acceptance and returned only when a beat leaves
    // the output, so every downstream queue is bounded by DEPTH.
    assign bus.rfull = (credits_used_q == CW'(DEPTH));
    assign accept    = bus.rstrobe && !bus.rfull;
    assign pop       = bus.ren && bus.rvalid;
    assign req_pop   = (state_q == S_REQ) && bus.mem_ack;
    // Tag emptiness is the pre-cycle value: an ack in this cycle cannot
    // cover a return in the same cycle.
    assign tag_pop   = bus.mem_rvalid && !tag_empty;

    assign req_empty  = (req_cnt == '0);
    assign tag_empty  = (tag_cnt == '0);
    assign data_empty = (data_cnt == '0);
    assign req_cnt_nx = req_cnt + CW'(accept) - CW'(req_pop);

    rrb_fifo #(.W(ADDR_W + 2), .DEPTH(DEPTH)) u_req_q (
        .clk(clk), .n_rst(n_rst),
        .push(accept), .din({bus.selected_addr, bus.tid_in}),
        .pop(req_pop), .dout(req_head), .cnt(req_cnt)
    );

    rrb_fifo #(.W(2), .DEPTH(DEPTH)) u_tag_q (
        .clk(clk), .n_rst(n_rst),
        .push(req_pop), .din(req_head[1:0]),
        .pop(tag_pop), .dout(tag_head), .cnt(tag_cnt)
    );

    rrb_fifo #(.W(DATA_W + 3), .DEPTH(DEPTH)) u_data_q (
        .clk(clk), .n_rst(n_rst),
        .push(tag_pop), .din({tag_head, bus.mem_rerr, bus.mem_rdata}),
        .pop(pop), .dout(data_head), .cnt(data_cnt)
    );

    // Issue FSM: enter REQ as soon as a request is (or is being) queued, so
    // mem_req rises the cycle after rstrobe; leave when the last one is acked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!req_empty || accept) state_d = S_REQ;
            S_REQ:  if (req_cnt_nx == '0)     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Credit counter and sticky stray-return flag.
    always_comb begin
        credits_used_d = credits_used_q + CW'(accept) - CW'(pop);
        stray_err_d    = stray_err_q | (bus.mem_rvalid && tag_empty);
    end

    // Control registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            credits_used_q <= '0;
            stray_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            credits_used_q <= credits_used_d;
            stray_err_q    <= stray_err_d;
        end
    end

    // mem_addr follows the queue head, which cannot move until the ack.
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_addr  = bus.mem_req ? req_head[ADDR_W+1:2] : '0;
    assign bus.rvalid    = !data_empty;
    assign bus.tid_out   = data_head[DATA_W+2:DATA_W+1];
    assign bus.rerr      = data_head[DATA_W];
    assign bus.rdata     = data_head[DATA_W-1:0];
    assign bus.stray_err = stray_err_q;
endmodule

// File: tb/tb_read_return_buffer.sv
// Directed bench for read_return_buffer: table-driven single-beat and
// ordering vectors, plus hand-written credit, held-request, stray and
// mid-flight reset sequences.
module tb_read_return_buffer;
    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    read_return_buffer_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    read_return_buffer #(.DEPTH(8), .ADDR_W(8), .DATA_W(64)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus)
    );

    typedef struct {
        logic        rstrobe;
        logic [7:0]  addr;
        logic [1:0]  tid;
        logic        ack;
        logic        mrv;
        logic [63:0] mdata;
        logic        merr;
        logic        ren;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_rvalid;
        logic [1:0]  e_tid;
        logic        e_rerr;
        logic [63:0] e_rdata;
        logic        e_rfull;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic [7:0] a, logic [1:0] t, logic ak,
                                logic mv, logic [63:0] md, logic me, logic rn,
                                logic erq, logic [7:0] ea, logic erv, logic [1:0] et,
                                logic ee, logic [63:0] ed);
        vec_t v;
        v.rstrobe = rs; v.addr = a; v.tid = t; v.ack = ak; v.mrv = mv;
        v.mdata = md; v.merr = me; v.ren = rn; v.e_req = erq; v.e_addr = ea;
        v.e_rvalid = erv; v.e_tid = et; v.e_rerr = ee; v.e_rdata = ed;
        v.e_rfull = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.rstrobe = 0; bus.selected_addr = '0; bus.tid_in = '0;
        bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        bus.mem_rerr = 0; bus.ren = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"},   bus.mem_req, 0);
        chk({tag, " mem_addr"},  bus.mem_addr, 0);
        chk({tag, " rvalid"},    bus.rvalid, 0);
        chk({tag, " rdata"},     bus.rdata, 0);
        chk({tag, " tid_out"},   bus.tid_out, 0);
        chk({tag, " rerr"},      bus.rerr, 0);
        chk({tag, " rfull"},     bus.rfull, 0);
        chk({tag, " stray_err"}, bus.stray_err, 0);
    endtask

    initial begin
        int popped;
        clr_inputs();
        #1 n_rst = 1'b0;

        // Reset held for 3 cycles, then released.
        repeat (3) @(posedge clk);
        #1 chk_all_zero("in_reset");
        n_rst = 1'b1;
        tick();
        chk_all_zero("after_reset");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d mem_req", i), bus.mem_req, 0);
        end

        // Single beat (v0..v5), then ordering/error tagging with ren held (v6..v12).
        tbl.push_back(mk(1, 8'h10, 2, 0, 0, 0, 0, 0,  1, 8'h10, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,      0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0001, 0, 0,
                         0, 8'h00, 1, 2, 0, 64'hDEAD_BEEF_0000_0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,      0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 0, 0, 0, 1,  1, 8'h20, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h21, 1, 1, 0, 0, 0, 1,  1, 8'h21, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 3, 1, 1, 64'hA0, 0, 1, 1, 8'h22, 1, 0, 0, 64'hA0));
        tbl.push_back(mk(1, 8'h23, 0, 1, 1, 64'hA1, 0, 1, 1, 8'h23, 1, 1, 0, 64'hA1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 64'hA2, 1, 1, 0, 8'h00, 1, 3, 1, 64'hA2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 64'hA3, 0, 1, 0, 8'h00, 1, 0, 0, 64'hA3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,      0, 8'h00, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            bus.rstrobe = tbl[i].rstrobe; bus.selected_addr = tbl[i].addr;
            bus.tid_in = tbl[i].tid; bus.mem_ack = tbl[i].ack;
            bus.mem_rvalid = tbl[i].mrv; bus.mem_rdata = tbl[i].mdata;
            bus.mem_rerr = tbl[i].merr; bus.ren = tbl[i].ren;
            tick();
            chk($sformatf("v%0d mem_req", i), bus.mem_req, tbl[i].e_req);
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d rvalid", i), bus.rvalid, tbl[i].e_rvalid);
            chk($sformatf("v%0d rfull", i), bus.rfull, tbl[i].e_rfull);
            if (tbl[i].e_rvalid) begin
                chk($sformatf("v%0d tid_out", i), bus.tid_out, tbl[i].e_tid);
                chk($sformatf("v%0d rerr", i), bus.rerr, tbl[i].e_rerr);
                chk($sformatf("v%0d rdata", i), bus.rdata, tbl[i].e_rdata);
            end
        end
        clr_inputs();

        // Credits: 8 requests with ack low, 9th ignored.
        for (int i = 0; i < 8; i++) begin
            bus.rstrobe = 1; bus.selected_addr = 8'h30 + 8'(i); bus.tid_in = 2'(i);
            tick();
            if (i == 0) chk("cred first mem_addr", bus.mem_addr, 8'h30);
            if (i == 6) chk("cred rfull after 7", bus.rfull, 0);
        end
        chk("cred rfull after 8", bus.rfull, 1);
        bus.selected_addr = 8'h99; bus.tid_in = 3;
        tick();
        bus.rstrobe = 0;
        chk("cred rfull after 9th", bus.rfull, 1);

        // Held request: ack low for 4 cycles keeps address stable.
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("held%0d mem_req", k), bus.mem_req, 1);
            chk($sformatf("held%0d mem_addr", k), bus.mem_addr, 8'h30);
        end
        bus.mem_ack = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) chk($sformatf("ack%0d mem_addr", k), bus.mem_addr, 8'h30 + 8'(k));
            else       chk("ack8 mem_req (9th dropped)", bus.mem_req, 0);
        end
        bus.mem_ack = 0;

        for (int i = 0; i < 8; i++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = 64'h100 + 64'(i); bus.mem_rerr = 0;
            tick();
        end
        bus.mem_rvalid = 0;
        chk("ret rvalid", bus.rvalid, 1);
        chk("ret rfull", bus.rfull, 1);
        chk("ret tid_out", bus.tid_out, 0);
        chk("ret stray_err", bus.stray_err, 0);
        bus.ren = 1;
        tick();
        bus.ren = 0;
        popped = 1;
        chk("pop1 rfull", bus.rfull, 0);
        chk("pop1 rdata", bus.rdata, 64'h101);
        chk("pop1 tid_out", bus.tid_out, 1);
        bus.ren = 1;
        for (int c = 0; c < 20; c++) begin
            if (bus.rvalid) begin
                chk($sformatf("drain%0d rdata", popped), bus.rdata, 64'h100 + 64'(popped));
                popped++;
            end
            tick();
        end
        bus.ren = 0;
        chk("drain total popped", 64'(popped), 8);
        chk("drain rvalid", bus.rvalid, 0);

        // Stray return with nothing in flight.
        bus.mem_rvalid = 1; bus.mem_rdata = 64'h5757;
        tick();
        bus.mem_rvalid = 0;
        chk("stray stray_err", bus.stray_err, 1);
        chk("stray rvalid", bus.rvalid, 0);
        repeat (3) tick();
        chk("stray sticky", bus.stray_err, 1);

        // Reset mid-flight with 3 beats buffered.
        for (int i = 0; i < 4; i++) begin
            bus.rstrobe = (i < 3); bus.selected_addr = 8'h40 + 8'(i);
            bus.tid_in = 2'(i + 1); bus.mem_ack = (i > 0);
            tick();
        end
        clr_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = 64'h200 + 64'(i);
            tick();
        end
        clr_inputs();
        chk("pre_rst rvalid", bus.rvalid, 1);
        chk("pre_rst tid_out", bus.tid_out, 1);
        n_rst = 1'b0;
        #1 chk_all_zero("async_rst");
        #3 n_rst = 1'b1;
        tick();
        chk("post_rst rfull", bus.rfull, 0);
        chk("post_rst rvalid", bus.rvalid, 0);
        chk("post_rst mem_req", bus.mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/read_return_buffer.md
Name: read_return_buffer

Overview:
- Sits directly downstream of axi_read, between the AXI read front end and the DRAM read backend.
- Accepts beat requests issued by axi_read (rstrobe, selected_addr, tid_in) and forwards them in order to the memory backend over a req/ack handshake.
- Tags each returning data beat with its transaction ID and buffers it in a show-ahead FIFO.
- Feeds axi_read's rdata/rvalid/tid_out/rerr inputs, drains on ren, and applies credit-based backpressure through rfull.

Parameters:
DEPTH, 8, total credits: maximum beats pending + in flight + buffered; power of two, >=2
ADDR_W, 8, request address width
DATA_W, 64, data beat width

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
rstrobe  input  1  beat request strobe from axi_read
selected_addr  input  ADDR_W  beat address, valid with rstrobe
tid_in  input  2  transaction ID, valid with rstrobe
mem_req  output  1  request valid to memory backend
mem_addr  output  ADDR_W  request address, held while mem_req && !mem_ack
mem_ack  input  1  backend accepts current request
mem_rdata  input  DATA_W  returned beat data
mem_rvalid  input  1  returned beat valid; returns arrive in request order
mem_rerr  input  1  beat error, valid with mem_rvalid
ren  input  1  pop head beat
rdata  output  DATA_W  head beat data
rvalid  output  1  FIFO non-empty
tid_out  output  2  head beat transaction ID
rerr  output  1  head beat error
rfull  output  1  no credits left
stray_err  output  1  sticky: mem_rvalid arrived with no beat in flight

Behaviour:
- Reset (async, n_rst=0): all queues empty, all counters 0, FSM in IDLE, stored entries cleared. Every output is 0. Reset mid-operation discards pending, in-flight and buffered beats; stray_err clears only on reset.
- Three internal queues, each DEPTH entries:
  - request queue {addr, tid}
  - tag queue {tid} for in-flight beats
  - data queue {tid, err, data}
- Credit counter `credits_used` ($clog2(DEPTH)+1 bits):
  - +1 on an accepted rstrobe; -1 on an accepted pop (ren && rvalid); both in the same cycle leave it unchanged.
  - rfull = (credits_used == DEPTH), registered from the counter.
- Request acceptance:
  - rstrobe while rfull=0: push {selected_addr, tid_in}.
  - rstrobe while rfull=1: ignored, no state change.
  - A pop in the same cycle does not free a credit until the next cycle.
- Issue FSM, states IDLE and REQ:
  - IDLE -> REQ when the request queue is non-empty (registered). Earliest mem_req is 1 cycle after rstrobe.
  - In REQ: mem_req=1 and mem_addr=head address.
  - On mem_ack: pop the request queue and push the head tid into the tag queue. Stay in REQ if another request remains (back-to-back, one per cycle), otherwise return to IDLE.
  - mem_addr must not change while mem_req=1 and mem_ack=0.
- Return path:
  - mem_rvalid with the tag queue non-empty: pop the tag and write {tag, mem_rerr, mem_rdata} into the data queue.
  - A beat acked and returned in the same cycle is legal only if the tag queue was already non-empty; otherwise it is a stray.
  - mem_rvalid with the tag queue empty: data dropped, stray_err set to 1.
  - The data queue cannot overflow, because credits bound it.
- Output path (show-ahead):
  - rvalid = data queue non-empty; rdata/tid_out/rerr present the head entry (registered storage, no combinational path from mem_*).
  - Latency mem_rvalid -> rvalid is 1 cycle.
  - ren && rvalid pops the head; ren while empty is ignored.
  - Simultaneous write and pop: both take effect, count unchanged, ordering preserved.
- All pointers wrap modulo DEPTH. Beat order at the output equals rstrobe acceptance order.

Test Plan:
- Reset/idle: hold n_rst=0 for 3 cycles, then release -> all outputs 0; no mem_req for 5 idle cycles.
- Single beat:
  - Stimulus: rstrobe with addr=0x10, tid=2; mem_ack on the first mem_req cycle; mem_rvalid 3 cycles later with data=0xDEAD_BEEF_0000_0001, err=0.
  - Required: mem_req 1 cycle after rstrobe with mem_addr=0x10; rvalid=1 the cycle after mem_rvalid with tid_out=2, rerr=0, data matching; ren pops it, rvalid=0.
- Backpressure/credits:
  - Stimulus: 8 rstrobes, mem_ack held low.
  - Required: rfull=1 after the 8th; a 9th rstrobe is ignored. After all 8 return and 1 pop, rfull=0 the following cycle; the total popped beats equal exactly 8.
- Held request: mem_ack low for 4 cycles -> mem_req and mem_addr stay stable; ack on cycle 5 -> the next queued address appears the following cycle.
- Order and error tagging:
  - Stimulus: tids 0,1,3,0; the 3rd return has mem_rerr=1; ren held high.
  - Required: output tids 0,1,3,0 and rerr sequence 0,0,1,0. Simultaneous write/pop cycles neither lose nor duplicate beats.
- Stray and reset mid-flight:
  - mem_rvalid with nothing in flight -> stray_err=1 and sticky; rvalid stays 0.
  - Assert n_rst low with 3 beats buffered -> all outputs 0 immediately (asynchronous); after release, rfull=0 and rvalid=0.
